// File: rtl/matrix_mem_sequencer.sv
// Load/execute/store engine: fetches matrix A then B from the single-port RAM,
// lets the combinational adder settle for one cycle, then writes the sum back.
module matrix_mem_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 256,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_c,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] mat_a,
  output logic [DATA_W-1:0] mat_b,
  input  logic [DATA_W-1:0] mat_c
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WR} state_t;

  // A read phase spans RD_LAT+1 cycles; the counter runs 0..RD_LAT.
  localparam logic [2:0] C_LAST = 3'(RD_LAT);

  state_t              r_state;
  logic [2:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr_b;
  logic [ADDR_W-1:0]   r_addr_c;
  logic                r_busy;
  logic                r_done;
  logic [ADDR_W-1:0]   r_ram_addr;
  logic                r_ram_wren;
  logic [DATA_W-1:0]   r_ram_wdata;
  logic [DATA_W-1:0]   r_mat_a;
  logic [DATA_W-1:0]   r_mat_b;
  logic                w_rd_last;

  assign w_rd_last = (r_cnt == C_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr_b    <= '0;
      r_addr_c    <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wren  <= 1'b0;
      r_ram_wdata <= '0;
      r_mat_a     <= '0;
      r_mat_b     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_addr_b   <= addr_b;
            r_addr_c   <= addr_c;
            r_ram_addr <= addr_a;
            r_cnt      <= '0;
            r_busy     <= 1'b1;
            r_state    <= RD_A;
          end
        end
        RD_A: begin
          if (w_rd_last) begin
            r_mat_a    <= ram_rdata;
            r_ram_addr <= r_addr_b;
            r_cnt      <= '0;
            r_state    <= RD_B;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        RD_B: begin
          if (w_rd_last) begin
            r_mat_b <= ram_rdata;
            r_state <= EXEC;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        EXEC: begin
          // mat_a/mat_b have been stable a full cycle, so mat_c is settled here.
          r_ram_wdata <= mat_c;
          r_ram_addr  <= r_addr_c;
          r_ram_wren  <= 1'b1;
          r_state     <= WR;
        end
        WR: begin
          r_ram_wren <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign ram_addr  = r_ram_addr;
  assign ram_wren  = r_ram_wren;
  assign ram_wdata = r_ram_wdata;
  assign mat_a     = r_mat_a;
  assign mat_b     = r_mat_b;

endmodule

// File: tb/tb_matrix_mem_sequencer.sv
// Bench for matrix_mem_sequencer: two instances (RD_LAT=2 and RD_LAT=1), each with a
// RAM and adder model, compared every cycle against an operation-level reference.
`timescale 1ns/1ps
module tb_matrix_mem_sequencer;
  localparam int AW = 8;
  localparam int DW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_v    [2];
  logic          start_v  [2];
  logic [AW-1:0] addr_a_v [2];
  logic [AW-1:0] addr_b_v [2];
  logic [AW-1:0] addr_c_v [2];
  logic          busy_v   [2];
  logic          done_v   [2];
  logic [AW-1:0] raddr_v  [2];
  logic          wren_v   [2];
  logic [DW-1:0] wdata_v  [2];
  logic [DW-1:0] rdata_v  [2];
  logic [DW-1:0] mat_a_v  [2];
  logic [DW-1:0] mat_b_v  [2];
  logic [DW-1:0] mat_c_v  [2];

  matrix_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2)) u_dut_r2 (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]),
    .addr_a(addr_a_v[0]), .addr_b(addr_b_v[0]), .addr_c(addr_c_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .ram_addr(raddr_v[0]), .ram_wren(wren_v[0]),
    .ram_wdata(wdata_v[0]), .ram_rdata(rdata_v[0]),
    .mat_a(mat_a_v[0]), .mat_b(mat_b_v[0]), .mat_c(mat_c_v[0])
  );

  matrix_mem_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut_r1 (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]),
    .addr_a(addr_a_v[1]), .addr_b(addr_b_v[1]), .addr_c(addr_c_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .ram_addr(raddr_v[1]), .ram_wren(wren_v[1]),
    .ram_wdata(wdata_v[1]), .ram_rdata(rdata_v[1]),
    .mat_a(mat_a_v[1]), .mat_b(mat_b_v[1]), .mat_c(mat_c_v[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  // Lane-wise 16-bit wrapping add: the adder's rule.
  function automatic logic [DW-1:0] add16(input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] s;
    s = '0;
    for (int l = 0; l < 16; l++) s[l*16 +: 16] = x[l*16 +: 16] + y[l*16 +: 16];
    return s;
  endfunction

  // RAM environment: read data valid RD_LAT cycles after the address is registered.
  logic [DW-1:0] ram      [2][256];
  logic [DW-1:0] pipe     [2][4];
  logic          pre_we   [2];
  logic [AW-1:0] pre_addr [2];
  logic [DW-1:0] pre_data [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      pipe[i][0] <= ram[i][raddr_v[i]];
      for (int s = 1; s < 4; s++) pipe[i][s] <= pipe[i][s-1];
      if (wren_v[i]) ram[i][raddr_v[i]] <= wdata_v[i];
      if (pre_we[i]) ram[i][pre_addr[i]] <= pre_data[i];
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      mat_c_v[i] = add16(mat_a_v[i], mat_b_v[i]);
      rdata_v[i] = pipe[i][lat_of(i)-1];
    end
  end

  // Reference model: one operation at a time, timed from its accept edge.
  logic [DW-1:0] exp_mem [2][256];
  bit            m_active [2] = '{1'b0, 1'b0};
  int            m_k   [2];
  int            m_ops [2] = '{0, 0};
  logic [AW-1:0] m_a [2];
  logic [AW-1:0] m_b [2];
  logic [AW-1:0] m_c [2];
  logic          m_busy [2];
  logic          m_done [2];
  logic          m_wren [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_wdata [2];
  logic [DW-1:0] m_mata [2];
  logic [DW-1:0] m_matb [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int r;
      r = lat_of(i);
      m_done[i] = 1'b0;
      if (pre_we[i]) exp_mem[i][pre_addr[i]] = pre_data[i];
      if (!rst_v[i]) begin
        if (m_active[i] && (m_k[i] + 1 == 2*r + 4)) exp_mem[i][m_c[i]] = m_wdata[i];
        m_active[i] = 1'b0;
        m_busy[i]   = 1'b0;
        m_wren[i]   = 1'b0;
        m_addr[i]   = '0;
        m_wdata[i]  = '0;
        m_mata[i]   = '0;
        m_matb[i]   = '0;
      end else if (m_active[i]) begin
        m_k[i]++;
        if (m_k[i] == r + 1) begin
          m_mata[i] = exp_mem[i][m_a[i]];
          m_addr[i] = m_b[i];
        end
        if (m_k[i] == 2*r + 2) m_matb[i] = exp_mem[i][m_b[i]];
        if (m_k[i] == 2*r + 3) begin
          m_wren[i]  = 1'b1;
          m_addr[i]  = m_c[i];
          m_wdata[i] = add16(exp_mem[i][m_a[i]], exp_mem[i][m_b[i]]);
        end
        if (m_k[i] == 2*r + 4) begin
          exp_mem[i][m_c[i]] = m_wdata[i];
          m_wren[i]   = 1'b0;
          m_busy[i]   = 1'b0;
          m_done[i]   = 1'b1;
          m_active[i] = 1'b0;
          m_ops[i]++;
        end
      end else if (start_v[i]) begin
        m_active[i] = 1'b1;
        m_k[i]      = 0;
        m_a[i]      = addr_a_v[i];
        m_b[i]      = addr_b_v[i];
        m_c[i]      = addr_c_v[i];
        m_addr[i]   = addr_a_v[i];
        m_busy[i]   = 1'b1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("busy[%0d]", i),  busy_v[i],  m_busy[i]);
        chk($sformatf("done[%0d]", i),  done_v[i],  m_done[i]);
        chk($sformatf("wren[%0d]", i),  wren_v[i],  m_wren[i]);
        chk($sformatf("raddr[%0d]", i), raddr_v[i], m_addr[i]);
        chk($sformatf("wdata[%0d]", i), wdata_v[i], m_wdata[i]);
        chk($sformatf("mat_a[%0d]", i), mat_a_v[i], m_mata[i]);
        chk($sformatf("mat_b[%0d]", i), mat_b_v[i], m_matb[i]);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_n, done_n, first_done, second_done, wren_first, wren_n, done1;
    bit wren_seen;
    logic [DW-1:0] old9;

    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b0; start_v[i] = 1'b0;
      addr_a_v[i] = '0; addr_b_v[i] = '0; addr_c_v[i] = '0;
      pre_we[i] = 1'b0; pre_addr[i] = '0; pre_data[i] = '0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", busy_v[0], 0);
    chk("reset_wren", wren_v[0], 0);
    chk("reset_mat_a", mat_a_v[0], 0);

    // start while reset is asserted must not be accepted
    start_v[0] = 1'b1; start_v[1] = 1'b1;
    repeat (3) @(negedge clk);
    chk("start_in_reset_busy0", busy_v[0], 0);
    chk("start_in_reset_busy1", busy_v[1], 0);
    start_v[0] = 1'b0; start_v[1] = 1'b0;

    for (int a = 0; a < 16; a++) begin
      pre_we[0]   = 1'b1;
      pre_addr[0] = 8'(a);
      if (a == 0)      pre_data[0] = {16{16'h0001}};
      else if (a == 1) pre_data[0] = {16{16'h0002}};
      else pre_data[0] = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
      pre_we[1]   = (a == 5);
      pre_addr[1] = 8'd5;
      pre_data[1] = {16{16'h7FFF}};
      @(negedge clk);
    end
    pre_we[0] = 1'b0; pre_we[1] = 1'b0;
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    @(negedge clk);

    // single op, then a second op started in the done cycle
    busy_n = 0; done_n = 0; first_done = -1; second_done = -1; wren_first = -1; wren_n = 0;
    start_v[0] = 1'b1; addr_a_v[0] = 8'd0; addr_b_v[0] = 8'd1; addr_c_v[0] = 8'd2;
    for (int k = 0; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 8 && busy_v[0]) busy_n++;
      if (done_v[0]) begin
        done_n++;
        if (first_done < 0) first_done = k; else second_done = k;
      end
      if (k <= 8 && wren_v[0]) begin
        wren_n++;
        if (wren_first < 0) wren_first = k;
      end
      if (k == 3) chk("mat_a_after_E3", mat_a_v[0], {16{16'h0001}});
      if (k == 7) begin
        chk("write_addr", raddr_v[0], 2);
        chk("write_data", wdata_v[0], {16{16'h0003}});
      end
      if (k == 8) begin
        start_v[0] = 1'b1; addr_a_v[0] = 8'd2; addr_b_v[0] = 8'd2; addr_c_v[0] = 8'd3;
      end else begin
        if (k == 9) chk("no_idle_busy", busy_v[0], 1);
        start_v[0]  = 1'b0;
        addr_a_v[0] = 8'($urandom_range(0, 15));
        addr_b_v[0] = 8'($urandom_range(0, 15));
        addr_c_v[0] = 8'($urandom_range(0, 15));
      end
    end
    chk("busy_cycles", busy_n, 8);
    chk("done_first_edge", first_done, 8);
    chk("done_second_edge", second_done, 17);
    chk("done_count", done_n, 2);
    chk("wren_first_edge", wren_first, 7);
    chk("wren_cycles", wren_n, 1);
    chk("ram2_sum", ram[0][2], {16{16'h0003}});
    chk("ram3_sum", ram[0][3], {16{16'h0006}});

    // start held high, addresses changing every cycle
    start_v[0] = 1'b1;
    for (int k = 0; k < 45; k++) begin
      addr_a_v[0] = 8'($urandom_range(0, 15));
      addr_b_v[0] = 8'($urandom_range(0, 15));
      addr_c_v[0] = 8'($urandom_range(0, 15));
      @(negedge clk);
    end
    start_v[0] = 1'b0;
    repeat (12) @(negedge clk);

    // reset while in RD_B
    start_v[0] = 1'b1; addr_a_v[0] = 8'd4; addr_b_v[0] = 8'd5; addr_c_v[0] = 8'd9;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    old9 = ram[0][9];
    rst_v[0] = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy_v[0], 0);
    chk("midrst_done", done_v[0], 0);
    chk("midrst_wren", wren_v[0], 0);
    chk("midrst_addr", raddr_v[0], 0);
    chk("midrst_mat_a", mat_a_v[0], 0);
    chk("midrst_mat_b", mat_b_v[0], 0);
    rst_v[0] = 1'b1;
    wren_seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (wren_v[0]) wren_seen = 1'b1;
    end
    chk("midrst_no_write", wren_seen, 0);
    chk("midrst_ram9", ram[0][9], old9);

    // randomized traffic with occasional resets
    for (int k = 0; k < 300; k++) begin
      start_v[0]  = ($urandom_range(0, 2) == 0);
      rst_v[0]    = ($urandom_range(0, 59) != 0);
      addr_a_v[0] = 8'($urandom_range(0, 15));
      addr_b_v[0] = 8'($urandom_range(0, 15));
      addr_c_v[0] = 8'($urandom_range(0, 15));
      @(negedge clk);
    end
    rst_v[0] = 1'b1; start_v[0] = 1'b0;
    repeat (12) @(negedge clk);

    // RD_LAT=1, all three addresses equal, lanes overflow into 0xFFFE
    done1 = -1;
    start_v[1] = 1'b1; addr_a_v[1] = 8'd5; addr_b_v[1] = 8'd5; addr_c_v[1] = 8'd5;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      start_v[1] = 1'b0;
      if (done_v[1] && done1 < 0) done1 = k;
    end
    chk("r1_done_edge", done1, 6);
    chk("r1_ram5", ram[1][5], {16{16'hFFFE}});

    for (int a = 0; a < 16; a++) chk($sformatf("mem0[%0d]", a), ram[0][a], exp_mem[0][a]);
    chk("mem1[5]", ram[1][5], exp_mem[1][5]);
    chk("ops_seen_r2", (m_ops[0] > 8) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
